// File: rtl/acc_mem_pkg.sv
// rtl/acc_mem_pkg.sv - shared types and default sizes for the accelerator memory arbiter
// Provides: arb_state_t (arbiter FSM states) and default parameter values.
package acc_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  localparam int DEF_NUM_ACC        = 4;
  localparam int DEF_ADDR_W         = 16;
  localparam int DEF_RD_DATA_W      = 512;
  localparam int DEF_WR_DATA_W      = 32;
  localparam int DEF_MEM_RD_LATENCY = 1;

endpackage

// File: rtl/acc_mem_arbiter_rr_picker.sv
// rtl/acc_mem_arbiter_rr_picker.sv - combinational round-robin picker
// Ports: req (request vector), ptr (search start index),
//        gnt (one-hot winner), gnt_idx (winner index), any (some request present).
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  int idx;

  // Walk offsets from farthest to nearest so the requester closest to ptr
  // overwrites every other candidate and wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int off = N - 1; off >= 0; off--) begin
      idx = (int'(ptr) + off) % N;
      if (req[idx]) begin
        gnt      = '0;
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acc_mem_arbiter.sv
// rtl/acc_mem_arbiter.sv - round-robin arbiter sharing one Data Memory port among accelerators
// Ports: req_rd_* / req_wr_* per-accelerator requests; rd_data, rd_data_valid, wr_done
//        responses; cpu_busy yields the port to the CPU; mem_* drive the memory; busy = in flight.
module acc_mem_arbiter
  import acc_mem_pkg::*;
#(
  parameter int NUM_ACC        = DEF_NUM_ACC,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int RD_DATA_W      = DEF_RD_DATA_W,
  parameter int WR_DATA_W      = DEF_WR_DATA_W,
  parameter int MEM_RD_LATENCY = DEF_MEM_RD_LATENCY
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_ACC-1:0]             req_rd_en,
  input  logic [NUM_ACC*ADDR_W-1:0]      req_rd_addr,
  input  logic [NUM_ACC-1:0]             req_wr_en,
  input  logic [NUM_ACC*ADDR_W-1:0]      req_wr_addr,
  input  logic [NUM_ACC*WR_DATA_W-1:0]   req_wr_data,
  output logic [RD_DATA_W-1:0]           rd_data,
  output logic [NUM_ACC-1:0]             rd_data_valid,
  output logic [NUM_ACC-1:0]             wr_done,
  input  logic                           cpu_busy,
  output logic                           mem_en,
  output logic                           mem_wr,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [WR_DATA_W-1:0]           mem_wdata,
  input  logic [RD_DATA_W-1:0]           mem_rdata,
  output logic                           busy
);

  localparam int IDX_W = $clog2(NUM_ACC);
  localparam int CNT_W = $clog2(MEM_RD_LATENCY + 1);

  arb_state_t             state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [IDX_W-1:0]       gnt_q, gnt_d;
  logic                   wr_q, wr_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [WR_DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RD_DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [NUM_ACC-1:0]     pick_gnt;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic [IDX_W-1:0]       ptr_next;

  rr_picker #(
    .N     (NUM_ACC),
    .IDX_W (IDX_W)
  ) u_picker (
    .req     (req_rd_en | req_wr_en),
    .ptr     (ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign ptr_next = (gnt_q == IDX_W'(NUM_ACC - 1)) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    wr_d          = wr_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    cnt_d         = cnt_q;
    rd_data_d     = rd_data_q;
    mem_en        = 1'b0;
    mem_wr        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    wr_done       = '0;
    rd_data_valid = '0;

    // Outputs are suppressed while rst_n is low so an abandoned transaction
    // never issues or pulses in the cycle the reset is sampled.
    if (rst_n) begin
      unique case (state_q)
        IDLE: begin
          if (!cpu_busy && pick_any) begin
            gnt_d   = pick_idx;
            // A requester asserting both strobes gets its write first.
            wr_d    = |(pick_gnt & req_wr_en);
            addr_d  = wr_d ? req_wr_addr[int'(pick_idx)*ADDR_W +: ADDR_W]
                           : req_rd_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
            wdata_d = req_wr_data[int'(pick_idx)*WR_DATA_W +: WR_DATA_W];
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          if (!cpu_busy) begin
            mem_en    = 1'b1;
            mem_wr    = wr_q;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
            if (wr_q) begin
              wr_done[gnt_q] = 1'b1;
              ptr_d          = ptr_next;
              state_d        = IDLE;
            end else begin
              cnt_d   = '0;
              state_d = WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (cnt_q == CNT_W'(MEM_RD_LATENCY - 1)) begin
            rd_data_d = mem_rdata;
            state_d   = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RESP: begin
          rd_data_valid[gnt_q] = 1'b1;
          ptr_d                = ptr_next;
          state_d              = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = rst_n && (state_q != IDLE);

endmodule
